// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: command-driven off/blink/running/bounce patterns
// with its own prescaler timebase and pause/resume.
module led_seq_ctrl #(
  parameter logic [31:0] TICK_DIV = 32'd49_999,
  parameter int unsigned LED_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [7:0]       cmd_period,
  input  logic             pause,
  output logic [LED_W-1:0] led_out,
  output logic             busy,
  output logic             step_tick
);

  localparam int unsigned PRESC_W = 32;
  localparam int unsigned CNT_W   = 8;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_BLINK   = 2'd1;
  localparam logic [1:0] MODE_RUNNING = 2'd2;
  localparam logic [1:0] MODE_BOUNCE  = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               tick_q, tick_d;
  logic               busy_q, busy_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               dir_q, dir_d;

  logic               accept_c;
  logic               base_tick_c;
  logic               step_due_c;
  logic [LED_W-1:0]   step_led_c;
  logic               step_dir_c;

  // Ready is a pure decode of state and pause so back-pressure is seen in the same cycle
  assign cmd_ready   = (state_q != ST_PAUSE) && !pause;
  assign accept_c    = cmd_valid && cmd_ready;
  assign base_tick_c = (presc_q == TICK_DIV);
  assign step_due_c  = base_tick_c && (cnt_q == (period_q - CNT_W'(1)));

  assign led_out   = led_q;
  assign busy      = busy_q;
  assign step_tick = tick_q;

  // Pattern advance for the latched mode; committed only when a step is due
  always_comb begin
    step_led_c = led_q;
    step_dir_c = dir_q;
    case (mode_q)
      MODE_BLINK:   step_led_c = ~led_q;
      MODE_RUNNING: step_led_c = {led_q[LED_W-2:0], led_q[LED_W-1]};
      MODE_BOUNCE: begin
        if (dir_q == DIR_LEFT) begin
          if (led_q[LED_W-1]) begin
            step_dir_c = DIR_RIGHT;
            step_led_c = led_q >> 1;
          end else begin
            step_led_c = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            step_dir_c = DIR_LEFT;
            step_led_c = led_q << 1;
          end else begin
            step_led_c = led_q >> 1;
          end
        end
      end
      default: step_led_c = led_q;
    endcase
  end

  // Next state: an accepted command overrides pause handling and any due step
  always_comb begin
    state_d  = state_q;
    led_d    = led_q;
    tick_d   = 1'b0;
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    period_d = period_q;
    dir_d    = dir_q;

    if (accept_c) begin
      if (cmd_mode == MODE_OFF) begin
        state_d = ST_IDLE;
        led_d   = '0;
        mode_d  = MODE_OFF;
      end else begin
        state_d  = ST_RUN;
        mode_d   = cmd_mode;
        period_d = (cmd_period == 8'd0) ? CNT_W'(1) : cmd_period;
        presc_d  = '0;
        cnt_d    = '0;
        dir_d    = DIR_LEFT;
        led_d    = (cmd_mode == MODE_BLINK) ? {LED_W{1'b1}} : LED_W'(1);
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (base_tick_c) begin
            presc_d = '0;
            if (step_due_c) begin
              cnt_d  = '0;
              led_d  = step_led_c;
              dir_d  = step_dir_c;
              tick_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
        end
        ST_PAUSE: begin
          if (!pause) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      led_q    <= '0;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
      presc_q  <= '0;
      cnt_q    <= '0;
      mode_q   <= MODE_OFF;
      period_q <= CNT_W'(1);
      dir_q    <= DIR_LEFT;
    end else begin
      state_q  <= state_d;
      led_q    <= led_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      dir_q    <= dir_d;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: directed vector table, hand-written
// pause/reset sequences, and randomized traffic against a pattern model.
module tb_led_seq_ctrl;

  localparam int TD = 3;
  localparam int W  = 4;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_mode;
  logic [7:0]   cmd_period;
  logic         pause;
  logic [W-1:0] led_out;
  logic         busy;
  logic         step_tick;

  int n_tests = 0;
  int n_fail  = 0;

  led_seq_ctrl #(
    .TICK_DIV (32'(TD)),
    .LED_W    (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_period (cmd_period),
    .pause      (pause),
    .led_out    (led_out),
    .busy       (busy),
    .step_tick  (step_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tracks run time in base-clock cycles and the number of
  // steps taken; the LED image is derived from the step count arithmetically.
  int m_state = 0;  // 0 idle, 1 run, 2 paused
  int m_mode  = 0;
  int m_per   = 1;
  int m_n     = 0;
  int m_k     = 0;
  bit m_tick  = 0;

  always @(posedge clk) begin
    m_tick = 0;
    if (rst) begin
      m_state = 0; m_mode = 0; m_per = 1; m_n = 0; m_k = 0;
    end else if (cmd_valid && m_state != 2 && !pause) begin
      if (cmd_mode == 2'd0) begin
        m_state = 0; m_mode = 0;
      end else begin
        m_state = 1; m_mode = int'(cmd_mode);
        m_per = (cmd_period == 8'd0) ? 1 : int'(cmd_period);
        m_n = 0; m_k = 0;
      end
    end else if (m_state == 1) begin
      if (pause) m_state = 2;
      else begin
        m_k++;
        if (m_k == m_per * (TD + 1)) begin
          m_k = 0; m_n++; m_tick = 1;
        end
      end
    end else if (m_state == 2 && !pause) begin
      m_state = 1;
    end
  end

  function automatic logic [W-1:0] m_led();
    int p, pos;
    logic [W-1:0] one;
    one = W'(1);
    if (m_state == 0) return '0;
    case (m_mode)
      1: return (m_n % 2 == 0) ? {W{1'b1}} : '0;
      2: return one << (m_n % W);
      3: begin
        p   = m_n % (2 * (W - 1));
        pos = (p < W - 1) ? p : 2 * (W - 1) - p;
        return one << pos;
      end
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic [W-1:0] el, input bit eb,
                         input bit er, input bit et);
    chk({nm, ".led"},   8'(led_out),   8'(el));
    chk({nm, ".busy"},  8'(busy),      8'(eb));
    chk({nm, ".ready"}, 8'(cmd_ready), 8'(er));
    chk({nm, ".tick"},  8'(step_tick), 8'(et));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; pause = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic send(input logic [1:0] md, input logic [7:0] per);
    cmd_valid = 1'b1; cmd_mode = md; cmd_period = per;
    cyc(1);
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    bit         vld;
    logic [1:0] mode;
    logic [7:0] per;
    bit         pse;
    int         gap;
    logic [W-1:0] led;
    bit         busy;
    bit         ready;
    bit         tick;
  } vec_t;

  function automatic vec_t mk(bit r, bit v, logic [1:0] md, logic [7:0] pr, bit ps,
                              int g, logic [W-1:0] l, bit b, bit rd, bit t);
    vec_t x;
    x.rst = r; x.vld = v; x.mode = md; x.per = pr; x.pse = ps; x.gap = g;
    x.led = l; x.busy = b; x.ready = rd; x.tick = t;
    return x;
  endfunction

  vec_t vq[$];

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_period = 8'd0; pause = 1'b0;

    // Each entry: drive inputs for one edge, then gap idle edges, then check
    // reset and idle hold
    vq.push_back(mk(1, 0, 0, 0, 0, 0,  4'b0000, 0, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0,  4'b0000, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 99, 4'b0000, 0, 1, 0));
    // running light, period 2: step every 8 cycles
    vq.push_back(mk(0, 1, 2, 2, 0, 0,  4'b0001, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 7,  4'b0010, 1, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,  4'b0010, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 6,  4'b0100, 1, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 7,  4'b1000, 1, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 7,  4'b0001, 1, 1, 1));
    // bounce, period 0 treated as 1
    vq.push_back(mk(0, 1, 3, 0, 0, 0,  4'b0001, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 3,  4'b0010, 1, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 3,  4'b0100, 1, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 3,  4'b1000, 1, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 3,  4'b0100, 1, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 3,  4'b0010, 1, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 3,  4'b0001, 1, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 3,  4'b0010, 1, 1, 1));
    // command on the edge a step is due: command wins, no rotation
    vq.push_back(mk(0, 1, 2, 2, 0, 7,  4'b0001, 1, 1, 0));
    vq.push_back(mk(0, 1, 1, 2, 0, 0,  4'b1111, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 6,  4'b1111, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,  4'b0000, 1, 1, 1));
    // pause together with a command: command refused, state goes to pause
    vq.push_back(mk(0, 1, 3, 1, 1, 0,  4'b0000, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,  4'b0000, 1, 1, 0));
    // off command from RUN
    vq.push_back(mk(0, 1, 2, 1, 0, 0,  4'b0001, 1, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 0,  4'b0000, 0, 1, 0));

    foreach (vq[i]) begin
      rst = vq[i].rst; cmd_valid = vq[i].vld; cmd_mode = vq[i].mode;
      cmd_period = vq[i].per; pause = vq[i].pse;
      cyc(1);
      rst = 1'b0; cmd_valid = 1'b0;
      cyc(vq[i].gap);
      chk_all($sformatf("vec%0d", i), vq[i].led, vq[i].busy, vq[i].ready, vq[i].tick);
    end

    // Pause two cycles after a blink toggle, hold, resume without losing time
    do_reset();
    send(2'd1, 8'd1);
    chk_all("pz_load", 4'b1111, 1, 1, 0);
    cyc(4);
    chk_all("pz_toggle", 4'b0000, 1, 1, 1);
    cyc(2);
    pause = 1'b1;
    cyc(50);
    chk_all("pz_hold", 4'b0000, 1, 0, 0);
    pause = 1'b0;
    cyc(1);
    chk_all("pz_resume", 4'b0000, 1, 1, 0);
    cyc(1);
    chk_all("pz_res1", 4'b0000, 1, 1, 0);
    cyc(1);
    chk_all("pz_res2", 4'b1111, 1, 1, 1);

    // Reset mid-bounce while moving right, then restart
    do_reset();
    send(2'd3, 8'd1);
    cyc(16);
    chk_all("rb_mid", 4'b0100, 1, 1, 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk_all("rb_rst", 4'b0000, 0, 1, 0);
    send(2'd3, 8'd1);
    chk_all("rb_load", 4'b0001, 1, 1, 0);
    cyc(4);
    chk_all("rb_step", 4'b0010, 1, 1, 1);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 299) == 0);
      cmd_valid  = ($urandom_range(0, 19) == 0);
      cmd_mode   = 2'($urandom_range(0, 3));
      cmd_period = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) pause = ~pause;
      cyc(1);
      chk("rand.led",   8'(led_out),   8'(m_led()));
      chk("rand.busy",  8'(busy),      8'(m_state != 0));
      chk("rand.ready", 8'(cmd_ready), 8'((m_state != 2) && !pause));
      chk("rand.tick",  8'(step_tick), 8'(m_tick));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Command-driven sequencer for a bank of LED_W LEDs; the board-level LED controller that sits between control logic (key handler, UART command parser) and the LED pins.
- Owns the timebase: a prescaler generates a base tick, and a per-command period counter schedules pattern steps.
- Runs one of four patterns (off, blink, running light, bounce), accepts new commands on a valid/ready handshake, supports pause/resume.

Parameters:
- TICK_DIV, 32'd49_999: base tick every TICK_DIV+1 clk cycles (1 ms at 50 MHz).
- LED_W, 4: number of LEDs; must be >= 2.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at posedge clk
- cmd_mode  in  2  0 = off, 1 = blink, 2 = running light, 3 = bounce
- cmd_period  in  8  base ticks per pattern step; 0 is treated as 1
- pause  in  1  level; freezes the sequence while high
- led_out  out  LED_W  LED drive, 1 = on; registered
- busy  out  1  high when state != IDLE
- step_tick  out  1  one-cycle pulse in the cycle after each pattern step is applied; registered

Behaviour:
- Reset, or rst held high: state = IDLE, led_out = 0, step_tick = 0, prescaler = 0, step_cnt = 0, mode = 0, period_eff = 1, dir = left. rst has priority over all other inputs.
- States: IDLE, RUN, PAUSE.
- cmd_ready = (state != PAUSE) && !pause. This is combinational from state and pause.
- Accept in IDLE or RUN:
  - cmd_mode = 0: go to IDLE; led_out <= 0 on the next edge.
  - Otherwise: go to RUN, latch mode, and set period_eff = max(cmd_period, 1). Clear prescaler and step_cnt.
  - Initial pattern on the next edge: blink = all ones; running = 1 in bit 0; bounce = 1 in bit 0 with dir = left.
  - An accepted command restarts the pattern even if it is identical to the current one.
- Prescaler: counts 0..TICK_DIV only in RUN.
  - base_tick is the internal condition prescaler == TICK_DIV; on it the prescaler wraps to 0.
  - In IDLE and PAUSE the prescaler and step_cnt hold.
- Step scheduling: on base_tick, if step_cnt == period_eff-1, take a step and set step_cnt <= 0; otherwise step_cnt increments.
  - First step lands exactly period_eff*(TICK_DIV+1) cycles after the accept edge, and every period_eff*(TICK_DIV+1) cycles after that.
- Step action by mode:
  - blink: led_out <= ~led_out.
  - running: rotate left, with the MSB wrapping to bit 0.
  - bounce: with dir = left, if led_out[LED_W-1] then dir <= right and shift right, else shift left. Mirror behaviour for dir = right at bit 0.
  - Resulting sequence with LED_W = 4: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, ...
- step_tick: high for exactly one cycle, the cycle after the edge on which led_out updated for a step. It is not asserted on command load.
- Pause:
  - RUN with pause = 1 goes to PAUSE on the next edge. led_out, prescaler and step_cnt freeze.
  - PAUSE with pause = 0 returns to RUN and resumes from the frozen counts, so no tick is lost or duplicated.
  - pause in IDLE has no effect on state; it only drops cmd_ready.
- Simultaneous events:
  - pause = 1 together with cmd_valid: pause wins and the command is not accepted, because ready is low.
  - Command accept on the same edge as a due step: the command wins and the step is discarded.
- Widths: step_cnt is 8 bits and the prescaler is 32 bits. All compares are unsigned.

Test Plan:
1. Reset then idle (TICK_DIV = 3): assert rst for 2 cycles -> led_out = 0000, busy = 0, cmd_ready = 1, step_tick = 0; then hold 100 cycles with no command -> outputs unchanged.
2. Running light (TICK_DIV = 3, LED_W = 4, mode 2, period 2): accept at edge T -> led_out = 0001 at T; 0010 at T+8, 0100 at T+16, 1000 at T+24, 0001 at T+32; step_tick high in the cycles after T+8, T+16, ...
3. Bounce (mode 3, period 0, TICK_DIV = 3): steps every 4 cycles -> sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010. Checks that period 0 is treated as 1.
4. Pause (blink, period 1, TICK_DIV = 3): raise pause 2 cycles after a toggle and hold 50 cycles -> led_out frozen, cmd_ready = 0, busy = 1; release -> next toggle 2 cycles after RUN re-entry.
5. Command priority (running light, period 2): issue mode 1 in the cycle a step is due -> no rotation occurs, led_out = 1111 on that edge, next toggle 8 cycles later; pause = 1 with cmd_valid -> command not accepted.
6. Mid-run reset and off: mode 0 in RUN -> led_out = 0, busy = 0 next edge; rst pulsed mid-bounce -> all state cleared, dir = left, next command restarts at 0001.
